lift_unsquash: RTL and testbench



---
 rtl/lift_pkg.sv | 35 +++
 rtl/lift_inv_core.sv | 80 ++++++++
 rtl/lift_unsquash.sv | 116 +++++++++++
 tb/tb_lift_unsquash.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lift_pkg.sv
// Shared definitions for the integer lifting pair: widths, shift amounts,
// serializer states and scalar reference functions for both directions.
package lift_pkg;

    localparam int unsigned LIFT_DW = 8;
    localparam int unsigned H_SHIFT = 1;
    localparam int unsigned L_SHIFT = 2;

    typedef enum logic [1:0] {
        StEmpty,
        StEven,
        StOdd
    } ser_state_e;

    function automatic logic [LIFT_DW-1:0] lift_fwd_h(input logic [LIFT_DW-1:0] e,
                                                      input logic [LIFT_DW-1:0] o);
        return o - (e >> H_SHIFT);
    endfunction

    function automatic logic [LIFT_DW-1:0] lift_fwd_l(input logic [LIFT_DW-1:0] e,
                                                      input logic [LIFT_DW-1:0] h);
        return e + (h >> L_SHIFT);
    endfunction

    function automatic logic [LIFT_DW-1:0] lift_inv_e(input logic [LIFT_DW-1:0] l,
                                                      input logic [LIFT_DW-1:0] h);
        return l - (h >> L_SHIFT);
    endfunction

    function automatic logic [LIFT_DW-1:0] lift_inv_o(input logic [LIFT_DW-1:0] h,
                                                      input logic [LIFT_DW-1:0] e);
        return h + (e >> H_SHIFT);
    endfunction

endpackage

// File: rtl/lift_inv_core.sv
// Two-stage inverse lifting datapath: stage A recovers the even sample,
// stage B recovers the odd sample and holds the pair for the serializer.
module lift_inv_core
    import lift_pkg::*;
#(
    parameter int unsigned DW = LIFT_DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_in_valid,
    output logic          o_in_ready,
    input  logic [DW-1:0] i_in_l,
    input  logic [DW-1:0] i_in_h,
    input  logic          i_b_free,
    input  logic          i_b_drain,
    input  logic          i_last_next,
    output logic          o_b_load,
    output logic          o_b_valid,
    output logic [DW-1:0] o_b_e,
    output logic [DW-1:0] o_b_o,
    output logic          o_b_last
);

    logic          r_rdy_en;
    logic          r_a_v;
    logic [DW-1:0] r_a_e;
    logic [DW-1:0] r_a_h;
    logic          r_b_v;
    logic [DW-1:0] r_b_e;
    logic [DW-1:0] r_b_o;
    logic          r_b_last;
    logic          w_adv;
    logic          w_accept;

    // B is only free in EMPTY once the previous pair has fully left it.
    assign w_adv      = r_a_v & ((i_b_free & ~r_b_v) | i_b_drain);
    assign o_in_ready = r_rdy_en & (~r_a_v | w_adv);
    assign w_accept   = i_in_valid & o_in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdy_en <= 1'b0;
            r_a_v    <= 1'b0;
            r_a_e    <= '0;
            r_a_h    <= '0;
        end else begin
            r_rdy_en <= 1'b1;
            if (w_accept) begin
                r_a_v <= 1'b1;
                r_a_e <= i_in_l - (i_in_h >> L_SHIFT);
                r_a_h <= i_in_h;
            end else if (w_adv) begin
                r_a_v <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_b_v    <= 1'b0;
            r_b_e    <= '0;
            r_b_o    <= '0;
            r_b_last <= 1'b0;
        end else if (w_adv) begin
            r_b_v    <= 1'b1;
            r_b_e    <= r_a_e;
            r_b_o    <= r_a_h + (r_a_e >> H_SHIFT);
            r_b_last <= i_last_next;
        end else if (i_b_drain) begin
            r_b_v <= 1'b0;
        end
    end

    assign o_b_load  = w_adv;
    assign o_b_valid = r_b_v;
    assign o_b_e     = r_b_e;
    assign o_b_o     = r_b_o;
    assign o_b_last  = r_b_last;

endmodule

// File: rtl/lift_unsquash.sv
// Inverse lifting stage: (L,H) pairs in, even then odd pixel out.
// Define LIFT_UNSQUASH_FRAME_CNT_EN to add the o_frame_cnt completed-frame counter.
module lift_unsquash
    import lift_pkg::*;
#(
    parameter int unsigned DW              = LIFT_DW,
    parameter int unsigned PAIRS_PER_FRAME = 32,
    parameter int unsigned CNT_W           = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_in_valid,
    output logic          o_in_ready,
    input  logic [DW-1:0] i_in_l,
    input  logic [DW-1:0] i_in_h,
    output logic          o_out_valid,
    input  logic          i_out_ready,
    output logic [DW-1:0] o_out_data,
    output logic          o_out_last
`ifdef LIFT_UNSQUASH_FRAME_CNT_EN
    ,
    output logic [15:0]   o_frame_cnt
`endif
);

    ser_state_e       r_state;
    ser_state_e       w_state_nxt;
    logic [CNT_W-1:0] r_pair_cnt;
    logic             w_out_hs;
    logic             w_b_free;
    logic             w_b_drain;
    logic             w_last_next;
    logic             w_b_load;
    logic             w_b_valid;
    logic [DW-1:0]    w_b_e;
    logic [DW-1:0]    w_b_o;
    logic             w_b_last;

    assign o_out_valid = (r_state != StEmpty);
    assign w_out_hs    = o_out_valid & i_out_ready;
    assign w_b_free    = (r_state == StEmpty);
    assign w_b_drain   = (r_state == StOdd) & w_out_hs;
    assign w_last_next = (r_pair_cnt == CNT_W'(PAIRS_PER_FRAME - 1));

    lift_inv_core #(
        .DW (DW)
    ) u_core (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_in_l      (i_in_l),
        .i_in_h      (i_in_h),
        .i_b_free    (w_b_free),
        .i_b_drain   (w_b_drain),
        .i_last_next (w_last_next),
        .o_b_load    (w_b_load),
        .o_b_valid   (w_b_valid),
        .o_b_e       (w_b_e),
        .o_b_o       (w_b_o),
        .o_b_last    (w_b_last)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StEmpty;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        o_out_data  = '0;
        o_out_last  = 1'b0;
        unique case (r_state)
            StEmpty: begin
                if (w_b_valid) w_state_nxt = StEven;
            end
            StEven: begin
                o_out_data = w_b_e;
                if (w_out_hs) w_state_nxt = StOdd;
            end
            StOdd: begin
                o_out_data = w_b_o;
                o_out_last = w_b_last;
                // Back-to-back pairs: reload B and go straight to the next even pixel.
                if (w_out_hs) w_state_nxt = w_b_load ? StEven : StEmpty;
            end
            default: w_state_nxt = StEmpty;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pair_cnt <= '0;
        end else if (w_b_load) begin
            r_pair_cnt <= w_last_next ? '0 : r_pair_cnt + 1'b1;
        end
    end

`ifdef LIFT_UNSQUASH_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_frame_cnt <= '0;
        end else if (w_out_hs && o_out_last) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign o_frame_cnt = r_frame_cnt;
`endif

endmodule

// File: tb/tb_lift_unsquash.sv
// Scoreboard bench for lift_unsquash: expected pixels are queued on input
// accept and compared as the DUT emits them.
`timescale 1ns/1ps
module tb_lift_unsquash;
    import lift_pkg::*;

    localparam int unsigned PPF = 32;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i_in_valid = 1'b0;
    logic       o_in_ready;
    logic [7:0] i_in_l = '0;
    logic [7:0] i_in_h = '0;
    logic       o_out_valid;
    logic       i_out_ready = 1'b0;
    logic [7:0] o_out_data;
    logic       o_out_last;
`ifdef LIFT_UNSQUASH_FRAME_CNT_EN
    logic [15:0] o_frame_cnt;
`endif

    int         n_checks = 0;
    int         n_pass = 0;
    logic [8:0] sb_q[$];
    int         hs_cycles[$];
    int         cyc = 0;
    int         pair_idx = 0;
    int         n_last_seen = 0;
    logic       stall_run = 1'b0;

    lift_unsquash u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .i_in_l      (i_in_l),
        .i_in_h      (i_in_h),
        .o_out_valid (o_out_valid),
        .i_out_ready (i_out_ready),
        .o_out_data  (o_out_data),
        .o_out_last  (o_out_last)
`ifdef LIFT_UNSQUASH_FRAME_CNT_EN
        ,
        .o_frame_cnt (o_frame_cnt)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, obs, exp, $time);
    endtask

    // Handshakes complete on the following rising edge; sampled mid-cycle here.
    always @(negedge clk) begin
        if (rst_n && o_out_valid && i_out_ready) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_underflow", sb_q.size(), 1);
            end else begin
                logic [8:0] exp_pix;
                exp_pix = sb_q.pop_front();
                check_eq("pix_data", o_out_data, exp_pix[7:0]);
                check_eq("pix_last", o_out_last, exp_pix[8]);
                if (o_out_last) n_last_seen++;
                hs_cycles.push_back(cyc);
            end
        end
    end

    task automatic send_pair(input logic [7:0] l, input logic [7:0] h,
                             input logic [7:0] e, input logic [7:0] o, output int waited);
        logic rdy;
        i_in_valid = 1'b1;
        i_in_l     = l;
        i_in_h     = h;
        waited     = 0;
        forever begin
            @(negedge clk);
            rdy = o_in_ready;
            @(posedge clk);
            #1;
            if (rdy) break;
            waited++;
            if (waited > 500) begin
                check_eq("send_timeout", waited, 0);
                break;
            end
        end
        i_in_valid = 1'b0;
        sb_q.push_back({1'b0, e});
        sb_q.push_back({(pair_idx == PPF - 1) ? 1'b1 : 1'b0, o});
        pair_idx = (pair_idx + 1) % PPF;
    endtask

    task automatic send_rand(output int waited);
        logic [7:0] e, o, h, l;
        e = 8'($urandom);
        o = 8'($urandom);
        h = lift_fwd_h(e, o);
        l = lift_fwd_l(e, h);
        send_pair(l, h, e, o, waited);
    endtask

    task automatic drain();
        int n = 0;
        while (sb_q.size() != 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        check_eq("drain_timeout", sb_q.size(), 0);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        sb_q.delete();
        pair_idx = 0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    initial begin
        int w, w1;
        // Reset values
        #12;
        check_eq("rst_in_ready", o_in_ready, 0);
        check_eq("rst_out_valid", o_out_valid, 0);
        check_eq("rst_out_data", o_out_data, 0);
        check_eq("rst_out_last", o_out_last, 0);
`ifdef LIFT_UNSQUASH_FRAME_CNT_EN
        check_eq("rst_frame_cnt", o_frame_cnt, 0);
`endif
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_eq("ready_after_rst", o_in_ready, 1);

        // Single pair and latency
        i_out_ready = 1'b1;
        send_pair(8'd205, 8'd240, 8'd145, 8'd56, w);
        @(posedge clk); #1;
        check_eq("lat_edge1_valid", o_out_valid, 0);
        @(posedge clk); #1;
        check_eq("lat_edge2_valid", o_out_valid, 1);
        check_eq("lat_first_pix", o_out_data, 145);
        drain();

        // Back-to-back pairs, one pixel per cycle
        hs_cycles.delete();
        send_pair(8'd205, 8'd240, 8'd145, 8'd56, w);
        send_pair(8'd65, 8'd65, 8'd49, 8'd89, w1);
        check_eq("b2b_in_wait", (w1 <= 1), 1);
        drain();
        check_eq("b2b_count", hs_cycles.size(), 4);
        if (hs_cycles.size() == 4) check_eq("b2b_consec", hs_cycles[3] - hs_cycles[0], 3);

        // Backpressure with three pairs offered
        i_out_ready = 1'b0;
        fork
            begin
                send_pair(8'd205, 8'd240, 8'd145, 8'd56, w);
                send_pair(8'd65, 8'd65, 8'd49, 8'd89, w);
                send_pair(8'd0, 8'd255, 8'd193, 8'd95, w);
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                check_eq("bp_valid", o_out_valid, 1);
                check_eq("bp_data", o_out_data, 145);
                check_eq("bp_in_ready", o_in_ready, 0);
                repeat (4) @(posedge clk);
                #1;
                check_eq("bp_hold_data", o_out_data, 145);
                check_eq("bp_hold_last", o_out_last, 0);
                i_out_ready = 1'b1;
            end
        join
        drain();

        // Two full frames of random pixels under random backpressure
        do_reset();
        n_last_seen = 0;
        stall_run   = 1'b1;
        fork
            begin
                for (int i = 0; i < 2 * PPF; i++) send_rand(w);
                drain();
                stall_run = 1'b0;
            end
            begin
                while (stall_run) begin
                    @(posedge clk);
                    #1;
                    i_out_ready = ($urandom_range(0, 3) != 0);
                end
            end
        join
        i_out_ready = 1'b1;
        check_eq("frame_last_count", n_last_seen, 2);

        // Asynchronous reset mid-stream
        for (int i = 0; i < 5; i++) send_rand(w);
        @(posedge clk);
        #3;
        check_eq("pre_rst_valid", o_out_valid, 1);
        rst_n = 1'b0;
        sb_q.delete();
        pair_idx = 0;
        #1;
        check_eq("async_rst_valid", o_out_valid, 0);
        check_eq("async_rst_last", o_out_last, 0);
        check_eq("async_rst_ready", o_in_ready, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_last_seen = 0;
        for (int i = 0; i < PPF; i++) send_rand(w);
        drain();
        check_eq("post_rst_last_count", n_last_seen, 1);

`ifdef LIFT_UNSQUASH_FRAME_CNT_EN
        do_reset();
        for (int i = 0; i < 3 * PPF; i++) send_rand(w);
        drain();
        check_eq("frame_cnt", o_frame_cnt, 3);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
